// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Arbitrates the single shared memory port between the instruction-fetch
//   requester and the load/store requester. The winner's request is
//   registered onto mem_* and held until mem_ready. Read data is latched into
//   the owner's rdata register, and the owner's valid pulses for one cycle.
//   Data wins ties, but a streak counter hands the port to a pending fetch
//   after MAX_D_STREAK consecutive data grants.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   if_req/if_addr    : fetch request (held until if_valid)
//   if_rdata/if_valid : fetched instruction, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be : load/store request (held until d_valid)
//   d_rdata/d_valid   : load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory request
//   mem_rdata/mem_ready : memory read data and completion
//   owner             : 00 none, 01 fetch, 10 data
module riscv_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [1:0]          owner
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } owner_t;

  state_t              state, state_next;
  owner_t              owner_q;
  logic                grant_d, grant_f;
  logic [STREAK_W-1:0] streak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grants are only issued from IDLE; requests are ignored elsewhere.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_req && (!if_req || (streak != STREAK_MAX));
        grant_f = if_req && !grant_d;
        if (grant_d || grant_f) state_next = ACCESS;
      end
      ACCESS: if (mem_ready) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner_q   <= OWN_NONE;
      streak    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else if (grant_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
      owner_q   <= OWN_DATA;
      // A data grant only happens with fetch pending while streak < max,
      // so the saturation branch is a guard rather than a live path.
      if (if_req)
        streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);
      else
        streak <= '0;
    end else if (grant_f) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_be    <= '1;
      owner_q   <= OWN_FETCH;
      streak    <= '0;
    end else if ((state == ACCESS) && mem_ready) begin
      mem_req <= 1'b0;
      if (!mem_we) begin
        if (owner_q == OWN_FETCH) if_rdata <= mem_rdata;
        else                      d_rdata  <= mem_rdata;
      end
    end else if (state == RESP) begin
      owner_q <= OWN_NONE;
    end
  end

  assign if_valid = (state == RESP) && (owner_q == OWN_FETCH);
  assign d_valid  = (state == RESP) && (owner_q == OWN_DATA);
  assign owner    = owner_q;

endmodule
